uart_tx_frame_engine: RTL and testbench

Parametrised UART transmit engine that replaces the fixed 8N1 transmit path behind the UART register interface. It contains a configurable-depth TX FIFO, an integrated baud-rate divider, and a frame state machine. The state machine supports 5–8 data bits, optional even/odd parity and 1 or 2 stop bits. It takes bytes over a valid/ready handshake from the register interface and drives the serial `tx_o` line; FIFO status outputs feed the count register and interrupt logic.

---
 rtl/uart_tx_frame_engine.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_frame_engine.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_engine.sv
// uart_tx_frame_engine: UART transmitter with TX FIFO, baud divider and 5-8 bit / parity / 1-2 stop frame FSM.
// Ports: clk_i/arst_i clock and async active-high reset; clk_div_i bit period minus one;
// data_bits_i, parity_en_i, parity_odd_i, stop2_i frame format; tx_en_i frame start enable;
// flush_i FIFO clear; data_i/data_valid_i/data_ready_o push handshake; fifo_count_o,
// almost_full_o FIFO status; busy_o frame in progress; tx_o registered serial line.
// Optional: define UART_TX_BREAK_EN to add break_i and the BREAK state.
module uart_tx_frame_engine #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2
) (
  input  logic                          clk_i,
  input  logic                          arst_i,
  input  logic [DIV_WIDTH-1:0]          clk_div_i,
  input  logic [1:0]                    data_bits_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          stop2_i,
  input  logic                          tx_en_i,
  input  logic                          flush_i,
  input  logic [7:0]                    data_i,
  input  logic                          data_valid_i,
`ifdef UART_TX_BREAK_EN
  input  logic                          break_i,
`endif
  output logic                          data_ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          almost_full_o,
  output logic                          busy_o,
  output logic                          tx_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`endif
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_count;
  state_t               r_state, w_state_n;
  logic [DIV_WIDTH-1:0] r_div, r_cnt, w_cnt_n;
  logic [2:0]           r_bit, w_bit_n, r_nbits;
  logic [7:0]           r_shift, w_shift_n, w_head, w_mask;
  logic                 r_par_en, r_par, r_stop2, r_tx, w_tx_n;
  logic                 w_push, w_pop, w_tick;
  assign data_ready_o  = r_count != CW'(FIFO_DEPTH);
  assign almost_full_o = r_count >= CW'(AF_LEVEL);
  assign fifo_count_o  = r_count;
  assign busy_o        = r_state != S_IDLE;
  assign tx_o          = r_tx;
  assign w_push        = data_valid_i && data_ready_o && !flush_i;
  assign w_head        = r_mem[r_rptr];
  assign w_mask        = 8'hFF >> (2'd3 - data_bits_i);
  assign w_tick        = r_cnt == r_div;
  always_ff @(posedge clk_i)
    if (w_push) r_mem[r_wptr] <= data_i;
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  // Frame config is sampled on every IDLE cycle, so the last sample is the one taken when the frame starts.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_div    <= '0;
      r_nbits  <= '0;
      r_par_en <= 1'b0;
      r_par    <= 1'b0;
      r_stop2  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
      if (r_state == S_IDLE) begin
        r_div    <= clk_div_i;
        r_nbits  <= {1'b1, data_bits_i};
        r_par_en <= parity_en_i;
        r_par    <= ^(w_head & w_mask) ^ parity_odd_i;
        r_stop2  <= stop2_i;
      end
    end
  end
  // w_tx_n is the line level for the next cycle, so tx_o changes on the same edge as the state.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = w_tick ? '0 : r_cnt + DIV_WIDTH'(1);
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_tx_n    = r_tx;
    w_pop     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_n   = '0;
        w_bit_n   = '0;
        w_shift_n = w_head;
        w_tx_n    = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (break_i) begin
          w_state_n = S_BREAK;
          w_tx_n    = 1'b0;
        end else
`endif
        if (tx_en_i && r_count != '0) begin
          w_pop     = 1'b1;
          w_state_n = S_START;
          w_tx_n    = 1'b0;
        end
      end
      S_START:
        if (w_tick) begin
          w_state_n = S_DATA;
          w_tx_n    = r_shift[0];
        end
      S_DATA:
        if (w_tick) begin
          w_bit_n   = r_bit + 3'd1;
          w_shift_n = r_shift >> 1;
          w_tx_n    = r_shift[1];
          if (r_bit == r_nbits) begin
            w_state_n = r_par_en ? S_PARITY : S_STOP;
            w_bit_n   = '0;
            w_tx_n    = r_par_en ? r_par : 1'b1;
          end
        end
      S_PARITY:
        if (w_tick) begin
          w_state_n = S_STOP;
          w_tx_n    = 1'b1;
        end
      S_STOP:
        if (w_tick) begin
          if (r_stop2 && r_bit == 3'd0) w_bit_n = 3'd1;
          else w_state_n = S_IDLE;
        end
`ifdef UART_TX_BREAK_EN
      // r_bit 0: line held low while break_i is set; r_bit 1: one bit period of mark before IDLE.
      S_BREAK:
        if (r_bit == 3'd0) begin
          w_cnt_n = '0;
          if (!break_i) begin
            w_bit_n = 3'd1;
            w_tx_n  = 1'b1;
          end
        end else if (w_tick) w_state_n = S_IDLE;
`endif
      default: w_state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// tb_uart_tx_frame_engine: scoreboard bench for uart_tx_frame_engine.
module tb_uart_tx_frame_engine;
  logic        clk_i = 1'b0, arst_i = 1'b1;
  logic [15:0] clk_div_i = '0;
  logic [1:0]  data_bits_i = 2'd3;
  logic        parity_en_i = 1'b0, parity_odd_i = 1'b0, stop2_i = 1'b0;
  logic        tx_en_i = 1'b0, flush_i = 1'b0, data_valid_i = 1'b0;
  logic [7:0]  data_i = '0;
  logic        data_ready_o, almost_full_o, busy_o, tx_o;
  logic [4:0]  fifo_count_o;
`ifdef UART_TX_BREAK_EN
  logic        break_i = 1'b0;
`endif
  int checks = 0, errors = 0;
  bit q[$];
  uart_tx_frame_engine dut (
    .clk_i(clk_i), .arst_i(arst_i), .clk_div_i(clk_div_i), .data_bits_i(data_bits_i),
    .parity_en_i(parity_en_i), .parity_odd_i(parity_odd_i), .stop2_i(stop2_i),
    .tx_en_i(tx_en_i), .flush_i(flush_i), .data_i(data_i), .data_valid_i(data_valid_i),
`ifdef UART_TX_BREAK_EN
    .break_i(break_i),
`endif
    .data_ready_o(data_ready_o), .fifo_count_o(fifo_count_o), .almost_full_o(almost_full_o),
    .busy_o(busy_o), .tx_o(tx_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [7:0] b);
    data_i = b;
    data_valid_i = 1'b1;
    @(negedge clk_i);
    data_valid_i = 1'b0;
  endtask
  task automatic expect_frame(input logic [7:0] b, input int n, input bit pe, input bit po, input bit s2, input int div);
    bit par;
    par = po;
    repeat (div + 1) q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      par ^= b[i];
      repeat (div + 1) q.push_back(b[i]);
    end
    if (pe) repeat (div + 1) q.push_back(par);
    repeat ((s2 ? 2 : 1) * (div + 1)) q.push_back(1'b1);
  endtask
  task automatic check_frame(input string tag, input int exp_wait, input bit mid);
    int w;
    bit e;
    w = 0;
    do begin
      @(negedge clk_i);
      w++;
    end while (!busy_o && w < 200);
    chk({tag, "_wait"}, w, exp_wait);
    for (int k = 0; q.size() > 0; k++) begin
      if (k > 0) @(negedge clk_i);
      if (mid && k == 2) begin
        parity_odd_i = 1'b0;
        clk_div_i = 16'd1;
      end
      e = q.pop_front();
      chk({tag, "_tx"}, tx_o, e);
      chk({tag, "_busy"}, busy_o, 1);
    end
    @(negedge clk_i);
    chk({tag, "_end_busy"}, busy_o, 0);
    chk({tag, "_end_tx"}, tx_o, 1);
  endtask
  initial begin
    @(negedge clk_i);
    chk("rst_tx", tx_o, 1);
    chk("rst_ready", data_ready_o, 1);
    chk("rst_count", fifo_count_o, 0);
    chk("rst_af", almost_full_o, 0);
    chk("rst_busy", busy_o, 0);
    arst_i = 1'b0;
    @(negedge clk_i);
    // 8N1 at four cycles per bit, start latency
    tx_en_i = 1'b1;
    clk_div_i = 16'd3;
    push(8'h55);
    chk("t1_count", fifo_count_o, 1);
    chk("t1_busy0", busy_o, 0);
    chk("t1_tx0", tx_o, 1);
    expect_frame(8'h55, 8, 0, 0, 0, 3);
    check_frame("t1", 1, 0);
    // 7 bits, even parity, two stop bits, one cycle per bit
    clk_div_i = 16'd0;
    data_bits_i = 2'd2;
    parity_en_i = 1'b1;
    stop2_i = 1'b1;
    push(8'hB5);
    expect_frame(8'hB5, 7, 1, 0, 1, 0);
    check_frame("t2", 1, 0);
    // 5 bits odd parity; config changed mid-frame applies to the next frame only
    tx_en_i = 1'b0;
    data_bits_i = 2'd0;
    parity_odd_i = 1'b1;
    stop2_i = 1'b0;
    push(8'h1F);
    push(8'h1F);
    expect_frame(8'h1F, 5, 1, 1, 0, 0);
    tx_en_i = 1'b1;
    check_frame("t3a", 1, 1);
    expect_frame(8'h1F, 5, 1, 0, 0, 1);
    check_frame("t3b", 1, 0);
    // fill with transmit disabled, overflow, flush beating a push
    tx_en_i = 1'b0;
    parity_en_i = 1'b0;
    data_bits_i = 2'd3;
    clk_div_i = 16'd3;
    for (int i = 0; i < 17; i++) begin
      push(8'(i));
      chk("t4_count", fifo_count_o, (i < 16) ? i + 1 : 16);
      chk("t4_af", almost_full_o, (i + 1 >= 14) ? 1 : 0);
      chk("t4_ready", data_ready_o, (i + 1 >= 16) ? 0 : 1);
    end
    chk("t4_idle", busy_o, 0);
    flush_i = 1'b1;
    data_valid_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    data_valid_i = 1'b0;
    chk("t4_flush_count", fifo_count_o, 0);
    chk("t4_flush_ready", data_ready_o, 1);
    chk("t4_flush_af", almost_full_o, 0);
    // asynchronous reset during data bit 3
    push(8'h00);
    push(8'h3C);
    tx_en_i = 1'b1;
    repeat (19) @(negedge clk_i);
    chk("t5_pre_busy", busy_o, 1);
    chk("t5_pre_tx", tx_o, 0);
    #1 arst_i = 1'b1;
    #1;
    chk("t5_rst_tx", tx_o, 1);
    chk("t5_rst_count", fifo_count_o, 0);
    chk("t5_rst_busy", busy_o, 0);
    @(negedge clk_i);
    arst_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      chk("t5_post_tx", tx_o, 1);
      chk("t5_post_busy", busy_o, 0);
    end
`ifdef UART_TX_BREAK_EN
    // break requested mid-frame with a second byte queued
    tx_en_i = 1'b0;
    clk_div_i = 16'd1;
    push(8'h00);
    push(8'h81);
    expect_frame(8'h00, 8, 0, 0, 0, 1);
    tx_en_i = 1'b1;
    @(negedge clk_i);
    chk("t6_start_tx", tx_o, q.pop_front());
    break_i = 1'b1;
    check_frame("t6a", 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t6_brk_tx", tx_o, 0);
      chk("t6_brk_busy", busy_o, 1);
    end
    chk("t6_brk_count", fifo_count_o, 1);
    break_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      chk("t6_mark_tx", tx_o, 1);
      chk("t6_mark_busy", busy_o, 1);
    end
    expect_frame(8'h81, 8, 0, 0, 0, 1);
    check_frame("t6b", 2, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
